// File: rtl/renkon_layer_seq_if.sv
// Host-config and renkon_ctrl handshake bundle for the layer sequencer.
// master = sequencer side, slave = host / controller side.
interface renkon_layer_seq_if #(
  parameter int unsigned LWIDTH  = 10,
  parameter int unsigned IMGSIZE = 12,
  parameter int unsigned LAYLOG  = 3
);
  logic                cfg_we;
  logic [LAYLOG-1:0]   cfg_idx;
  logic [LWIDTH-1:0]   cfg_total_in;
  logic [LWIDTH-1:0]   cfg_total_out;
  logic [LWIDTH-1:0]   cfg_img_size;
  logic [LWIDTH-1:0]   cfg_fil_size;
  logic [LWIDTH-1:0]   cfg_pool_size;
  logic [LAYLOG:0]     nlayer;
  logic                start;
  logic                ack;
  logic                req;
  logic [LWIDTH-1:0]   total_in;
  logic [LWIDTH-1:0]   total_out;
  logic [LWIDTH-1:0]   img_size;
  logic [LWIDTH-1:0]   fil_size;
  logic [LWIDTH-1:0]   pool_size;
  logic [IMGSIZE-1:0]  in_base;
  logic [IMGSIZE-1:0]  out_base;
  logic [LAYLOG-1:0]   layer_idx;
  logic                busy;
  logic                done;

  modport master (
    input  cfg_we, cfg_idx, cfg_total_in, cfg_total_out, cfg_img_size,
           cfg_fil_size, cfg_pool_size, nlayer, start, ack,
    output req, total_in, total_out, img_size, fil_size, pool_size,
           in_base, out_base, layer_idx, busy, done
  );

  modport slave (
    output cfg_we, cfg_idx, cfg_total_in, cfg_total_out, cfg_img_size,
           cfg_fil_size, cfg_pool_size, nlayer, start, ack,
    input  req, total_in, total_out, img_size, fil_size, pool_size,
           in_base, out_base, layer_idx, busy, done
  );
endinterface

// File: rtl/renkon_layer_seq.sv
// Layer sequencer: walks a small layer-config table, handshaking each layer with
// renkon_ctrl and ping-ponging image buffers between layers.
module renkon_layer_seq #(
  parameter int unsigned LWIDTH   = 10,
  parameter int unsigned IMGSIZE  = 12,
  parameter int unsigned MAXLAYER = 8,
  parameter int unsigned LAYLOG   = 3,
  parameter int unsigned BASE_A   = 0,
  parameter int unsigned BASE_B   = 2048
) (
  input  logic               clk,
  input  logic               xrst,
  renkon_layer_seq_if.master bus
);
  localparam int unsigned NW = LAYLOG + 1;
  localparam logic [IMGSIZE-1:0] BA = IMGSIZE'(BASE_A);
  localparam logic [IMGSIZE-1:0] BB = IMGSIZE'(BASE_B);

  typedef struct packed {
    logic [LWIDTH-1:0] total_in;
    logic [LWIDTH-1:0] total_out;
    logic [LWIDTH-1:0] img_size;
    logic [LWIDTH-1:0] fil_size;
    logic [LWIDTH-1:0] pool_size;
  } geom_t;

  typedef enum logic [2:0] {
    IDLE, LOAD, REQ, WAIT_LO, WAIT_HI, NEXT, FIN
  } state_t;

  geom_t              table_q [MAXLAYER];
  state_t             state_q, state_d;
  geom_t              geom_q, geom_d;
  logic [NW-1:0]      nlayer_q, nlayer_d;
  logic [LAYLOG-1:0]  idx_q, idx_d;
  logic [IMGSIZE-1:0] in_base_q, in_base_d, out_base_q, out_base_d;
  logic               req_q, req_d, busy_q, busy_d, done_q, done_d;

  // Config table: intentionally not reset, frozen while a run is active.
  always_ff @(posedge clk) begin
    if (bus.cfg_we && !busy_q && (int'(bus.cfg_idx) < int'(MAXLAYER))) begin
      table_q[bus.cfg_idx] <= '{total_in:  bus.cfg_total_in,
                                total_out: bus.cfg_total_out,
                                img_size:  bus.cfg_img_size,
                                fil_size:  bus.cfg_fil_size,
                                pool_size: bus.cfg_pool_size};
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    geom_d     = geom_q;
    nlayer_d   = nlayer_q;
    idx_d      = idx_q;
    in_base_d  = in_base_q;
    out_base_d = out_base_q;
    req_d      = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          nlayer_d   = (bus.nlayer > NW'(MAXLAYER)) ? NW'(MAXLAYER) : bus.nlayer;
          idx_d      = '0;
          in_base_d  = BA;
          out_base_d = BB;
          busy_d     = 1'b1;
          state_d    = (bus.nlayer == '0) ? FIN : LOAD;
        end
      end
      LOAD: begin
        geom_d  = table_q[idx_q];
        state_d = REQ;
      end
      REQ: begin
        if (bus.ack) begin
          req_d   = 1'b1;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: if (!bus.ack) state_d = WAIT_HI;
      WAIT_HI: if (bus.ack) state_d = NEXT;
      NEXT: begin
        if (NW'(idx_q) == nlayer_q - NW'(1)) begin
          state_d = FIN;
        end else begin
          idx_d      = idx_q + LAYLOG'(1);
          in_base_d  = out_base_q;
          out_base_d = in_base_q;
          state_d    = LOAD;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any run without a done pulse.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q    <= IDLE;
      geom_q     <= '0;
      nlayer_q   <= '0;
      idx_q      <= '0;
      in_base_q  <= BA;
      out_base_q <= BB;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      geom_q     <= geom_d;
      nlayer_q   <= nlayer_d;
      idx_q      <= idx_d;
      in_base_q  <= in_base_d;
      out_base_q <= out_base_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.req       = req_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.layer_idx = idx_q;
  assign bus.in_base   = in_base_q;
  assign bus.out_base  = out_base_q;
  assign bus.total_in  = geom_q.total_in;
  assign bus.total_out = geom_q.total_out;
  assign bus.img_size  = geom_q.img_size;
  assign bus.fil_size  = geom_q.fil_size;
  assign bus.pool_size = geom_q.pool_size;
endmodule

// File: tb/tb_renkon_layer_seq.sv
// Directed bench for renkon_layer_seq: a controller ack model plus a scoreboard
// of expected per-layer geometry/bases checked on every req pulse.
`timescale 1ns/1ps
module tb_renkon_layer_seq;
  localparam int unsigned LW = 10;
  localparam int unsigned IS = 12;
  localparam int unsigned ML = 8;
  localparam int unsigned LL = 3;
  localparam logic [IS-1:0] BA = 12'd0;
  localparam logic [IS-1:0] BB = 12'd2048;

  typedef struct packed {
    logic [LW-1:0] tin, tout, img, fil, pool;
  } geom_t;

  typedef struct packed {
    geom_t         g;
    logic [IS-1:0] ib;
    logic [IS-1:0] ob;
    logic [LL-1:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic xrst;
  always #5 clk = ~clk;

  renkon_layer_seq_if #(.LWIDTH(LW), .IMGSIZE(IS), .LAYLOG(LL)) bus ();

  renkon_layer_seq #(
    .LWIDTH(LW), .IMGSIZE(IS), .MAXLAYER(ML), .LAYLOG(LL),
    .BASE_A(0), .BASE_B(2048)
  ) dut (
    .clk  (clk),
    .xrst (xrst),
    .bus  (bus)
  );

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    req_cnt = 0;
  int    done_cnt = 0;
  int    done_cyc = 0;
  int    last_req_cyc = 0;
  int    ack_rise_cyc = 0;
  int    start_cyc = 0;
  int    ack_lat = 20;
  bit    ack_force_lo = 1'b0;
  exp_t  sb[$];
  geom_t tbl[ML];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic geom_t cur_geom();
    return '{tin: bus.total_in, tout: bus.total_out, img: bus.img_size,
             fil: bus.fil_size, pool: bus.pool_size};
  endfunction

  task automatic cfg_write(input int idx, input geom_t g, input bit upd_model);
    bus.cfg_we        = 1'b1;
    bus.cfg_idx       = LL'(idx);
    bus.cfg_total_in  = g.tin;
    bus.cfg_total_out = g.tout;
    bus.cfg_img_size  = g.img;
    bus.cfg_fil_size  = g.fil;
    bus.cfg_pool_size = g.pool;
    tick(1);
    bus.cfg_we = 1'b0;
    if (upd_model) tbl[idx] = g;
  endtask

  // Push the expected layer sequence, then pulse start for one cycle.
  task automatic start_run(input int n);
    int nn;
    exp_t e;
    nn = (n > int'(ML)) ? int'(ML) : n;
    for (int i = 0; i < nn; i++) begin
      e.g   = tbl[i];
      e.ib  = (i % 2 == 0) ? BA : BB;
      e.ob  = (i % 2 == 0) ? BB : BA;
      e.idx = LL'(i);
      sb.push_back(e);
    end
    bus.nlayer = (LL+1)'(n);
    bus.start  = 1'b1;
    start_cyc  = cyc;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < limit) begin
      tick(1);
      n++;
    end
    check(tag, 64'(done_cnt - d0), 64'd1);
  endtask

  // renkon_ctrl model: drops ack after req, stays busy ack_lat cycles, then idles.
  initial begin : ctrl_model
    int bsy;
    bsy = 0;
    bus.ack = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (!xrst) begin
        bsy = 0;
        bus.ack = 1'b1;
      end else if (bsy > 0) begin
        bsy--;
        if (bsy == 0) begin
          bus.ack = 1'b1;
          ack_rise_cyc = cyc + 1;
        end
      end else if (bus.req) begin
        bus.ack = 1'b0;
        bsy = ack_lat;
      end else begin
        bus.ack = !ack_force_lo;
      end
    end
  end

  // Scoreboard side: every req pulse must match the next expected layer.
  initial begin : req_mon
    bit   prev_req;
    exp_t e;
    prev_req = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (xrst && bus.req) begin
        req_cnt++;
        last_req_cyc = cyc;
        check("req_single_cycle", 64'(prev_req), 64'd0);
        check("req_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("req_geom", 64'(cur_geom()), 64'(e.g));
          check("req_in_base", 64'(bus.in_base), 64'(e.ib));
          check("req_out_base", 64'(bus.out_base), 64'(e.ob));
          check("req_layer_idx", 64'(bus.layer_idx), 64'(e.idx));
        end
      end
      prev_req = bus.req;
    end
  end

  initial begin : done_mon
    forever begin
      @(posedge clk);
      #1;
      if (xrst && bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial begin : main
    int r0, d0, n;
    geom_t g;
    xrst = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.nlayer = '0; bus.start = 1'b0;
    bus.cfg_total_in = '0; bus.cfg_total_out = '0; bus.cfg_img_size = '0;
    bus.cfg_fil_size = '0; bus.cfg_pool_size = '0;
    tick(3);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_in_base", 64'(bus.in_base), 64'(BA));
    check("rst_out_base", 64'(bus.out_base), 64'(BB));
    xrst = 1'b1;
    tick(2);
    check("rst_req", 64'(bus.req), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_layer_idx", 64'(bus.layer_idx), 64'd0);
    check("rst_geom", 64'(cur_geom()), 64'd0);

    // T1: empty run
    r0 = req_cnt;
    start_run(0);
    check("t1_busy_c1", 64'(bus.busy), 64'd1);
    check("t1_done_c1", 64'(bus.done), 64'd0);
    tick(1);
    check("t1_busy_c2", 64'(bus.busy), 64'd0);
    check("t1_done_c2", 64'(bus.done), 64'd1);
    tick(1);
    check("t1_done_pulse", 64'(bus.done), 64'd0);
    tick(3);
    check("t1_no_req", 64'(req_cnt - r0), 64'd0);

    // T2: single layer, slow controller
    g = '{tin: 10'd16, tout: 10'd32, img: 10'd12, fil: 10'd5, pool: 10'd2};
    cfg_write(0, g, 1'b1);
    ack_lat = 20;
    r0 = req_cnt;
    start_run(1);
    wait_done("t2_done", 200);
    check("t2_req_count", 64'(req_cnt - r0), 64'd1);
    check("t2_start_to_req", 64'(last_req_cyc - start_cyc), 64'd3);
    check("t2_done_after_ack", 64'(done_cyc - ack_rise_cyc), 64'd2);
    check("t2_geom_hold", 64'(cur_geom()), 64'(g));
    check("t2_busy_after", 64'(bus.busy), 64'd0);

    // T3: three layers, ping-pong bases
    cfg_write(1, '{tin: 10'd32, tout: 10'd64, img: 10'd6, fil: 10'd3, pool: 10'd1}, 1'b1);
    cfg_write(2, '{tin: 10'd64, tout: 10'd10, img: 10'd4, fil: 10'd1, pool: 10'd4}, 1'b1);
    ack_lat = 5;
    r0 = req_cnt;
    start_run(3);
    wait_done("t3_done", 300);
    check("t3_req_count", 64'(req_cnt - r0), 64'd3);
    check("t3_final_in_base", 64'(bus.in_base), 64'(BA));
    check("t3_final_idx", 64'(bus.layer_idx), 64'd2);

    // T4: controller busy at start; table writes during the run are dropped
    ack_force_lo = 1'b1;
    tick(2);
    r0 = req_cnt;
    start_run(2);
    cfg_write(0, '{tin: 10'd1, tout: 10'd2, img: 10'd3, fil: 10'd4, pool: 10'd5}, 1'b0);
    cfg_write(1, '{tin: 10'd7, tout: 10'd7, img: 10'd7, fil: 10'd7, pool: 10'd7}, 1'b0);
    tick(6);
    check("t4_req_withheld", 64'(req_cnt - r0), 64'd0);
    check("t4_busy_stall", 64'(bus.busy), 64'd1);
    ack_force_lo = 1'b0;
    wait_done("t4_done", 300);
    check("t4_req_count", 64'(req_cnt - r0), 64'd2);
    r0 = req_cnt;
    start_run(2);
    wait_done("t4_rerun_done", 300);
    check("t4_rerun_reqs", 64'(req_cnt - r0), 64'd2);

    // T5: async reset while layer 1 is in flight
    ack_lat = 10;
    r0 = req_cnt;
    d0 = done_cnt;
    start_run(3);
    n = 0;
    while (req_cnt < r0 + 2 && n < 200) begin
      tick(1);
      n++;
    end
    check("t5_reached_layer1", 64'(req_cnt - r0), 64'd2);
    tick(4);
    xrst = 1'b0;
    #1;
    check("t5_rst_busy", 64'(bus.busy), 64'd0);
    check("t5_rst_req", 64'(bus.req), 64'd0);
    check("t5_rst_in_base", 64'(bus.in_base), 64'(BA));
    check("t5_rst_out_base", 64'(bus.out_base), 64'(BB));
    sb.delete();
    tick(2);
    xrst = 1'b1;
    tick(3);
    check("t5_no_done", 64'(done_cnt - d0), 64'd0);
    r0 = req_cnt;
    start_run(3);
    wait_done("t5_fresh_done", 300);
    check("t5_fresh_reqs", 64'(req_cnt - r0), 64'd3);

    // T6: nlayer above table depth saturates; repeated start while busy ignored
    for (int i = 0; i < int'(ML); i++)
      cfg_write(i, '{tin: LW'(100 + i), tout: LW'(200 + 3 * i), img: LW'(i + 1),
                     fil: LW'(2 * i + 1), pool: LW'(i % 3)}, 1'b1);
    ack_lat = 3;
    r0 = req_cnt;
    d0 = done_cnt;
    start_run(9);
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      if (bus.busy && (n % 3 == 0)) begin
        bus.nlayer = 4'd1;
        bus.start  = 1'b1;
        tick(1);
        bus.start = 1'b0;
      end else begin
        tick(1);
      end
      n++;
    end
    tick(6);
    check("t6_req_count", 64'(req_cnt - r0), 64'(ML));
    check("t6_done_count", 64'(done_cnt - d0), 64'd1);
    check("t6_final_idx", 64'(bus.layer_idx), 64'(ML - 1));
    check("t6_idle_after", 64'(bus.busy), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
